yazmac_yaz_hakem: RTL and testbench

- Arbiter for the single register-file write port (yo_yaz_*). Two requesters share it: the in-order pipeline writeback, and a late-result stream from multicycle units (divider, load return) arriving on a valid/ready handshake.
- Late results are buffered in a small FIFO and drained into free write slots.
- An age counter forces a pipeline stall so that buffered results cannot starve.
- The output write port is registered and sits directly in front of the register file.

---
 rtl/yazmac_yaz_hakem.sv | 201 ++++++++++++++++++++
 tb/tb_yazmac_yaz_hakem.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/yazmac_yaz_hakem.sv
`default_nettype none
// ============================================================================
//  Module   : yazmac_yaz_hakem
//  Purpose  : Arbiter for the single register-file write port. The in-order
//             pipeline writeback and a late-result stream (divider, load
//             return) share the port. Late results wait in a small FIFO and
//             drain into write slots the pipeline leaves free. An age counter
//             stalls the pipeline so that buffered results cannot starve.
//             The write port is registered and feeds the register file
//             directly.
//  Ports    : clk_g / rstn_g            clock, asynchronous active-low reset
//             bw_yaz_g/_hedef_g/_veri_g pipeline writeback request
//             gc_gecerli_g/_hedef_g/_veri_g, gc_hazir_c
//                                       late-result valid/ready handshake
//             boru_durdur_c             stall request to the pipeline
//             yo_yaz_c/_hedef_c/_veri_c registered register-file write port
//             doluluk_c                 current FIFO occupancy
//  Revision : 1.0  initial release
// ============================================================================
module yazmac_yaz_hakem #(
    parameter int DERINLIK = 2,   // late-result FIFO depth, 1..8
    parameter int ESIK     = 4    // unserved cycles before a forced stall, >= 1
) (
    input  logic        clk_g,
    input  logic        rstn_g,

    input  logic        bw_yaz_g,
    input  logic [4:0]  bw_hedef_g,
    input  logic [31:0] bw_veri_g,

    input  logic        gc_gecerli_g,
    input  logic [4:0]  gc_hedef_g,
    input  logic [31:0] gc_veri_g,
    output logic        gc_hazir_c,

    output logic        boru_durdur_c,

    output logic        yo_yaz_c,
    output logic [4:0]  yo_yaz_hedef_c,
    output logic [31:0] yo_yaz_veri_c,
    output logic [3:0]  doluluk_c
);

    // ------------------------------------------------------------------------
    // Derived widths
    // ------------------------------------------------------------------------
    localparam int C_PTR_W = (DERINLIK > 1) ? $clog2(DERINLIK) : 1;
    localparam int C_YAS_W = $clog2(ESIK + 1);
    localparam int C_ENT_W = 5 + 32;

    localparam logic [C_PTR_W-1:0] C_PTR_SON = C_PTR_W'(DERINLIK - 1);
    localparam logic [3:0]         C_DOLU    = 4'(DERINLIK);
    localparam logic [C_YAS_W-1:0] C_ESIK    = C_YAS_W'(ESIK);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [C_ENT_W-1:0] kuyruk_q [DERINLIK];

    logic [C_PTR_W-1:0] yaz_ptr_q, yaz_ptr_d;
    logic [C_PTR_W-1:0] oku_ptr_q, oku_ptr_d;
    logic [3:0]         sayac_q,   sayac_d;
    logic [C_YAS_W-1:0] yas_q,     yas_d;

    logic               yo_yaz_q,   yo_yaz_d;
    logic [4:0]         yo_hedef_q, yo_hedef_d;
    logic [31:0]        yo_veri_q,  yo_veri_d;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic               w_bos;
    logic               w_dolu;
    logic               w_yas_doldu;
    logic               w_durdur;
    logic               w_hazir;
    logic               w_el_sikisma;     // late handshake fires
    logic               w_gc_gecerli_hdf; // handshake with a non-x0 target
    logic               w_bw_etkin;       // effective pipeline request
    logic               w_cek;            // pop FIFO head into the write slot
    logic               w_baypas;         // late result goes straight to port
    logic               w_it;             // push late result into FIFO
    logic [C_ENT_W-1:0] w_bas;            // FIFO head entry

    assign w_bas = kuyruk_q[oku_ptr_q];

    always_comb begin
        w_bos       = (sayac_q == 4'd0);
        w_dolu      = (sayac_q == C_DOLU);
        w_yas_doldu = (yas_q >= C_ESIK);

        // A stall is only useful when there is something to drain.
        w_durdur    = !w_bos && (w_dolu || w_yas_doldu);

        // Ready depends on the current count only: a full FIFO does not
        // accept even when the head pops in the same cycle.
        w_hazir     = !w_dolu;

        w_el_sikisma      = gc_gecerli_g && w_hazir;
        w_gc_gecerli_hdf  = w_el_sikisma && (gc_hedef_g != 5'd0);

        // While stalled the pipeline holds its request and re-presents it.
        w_bw_etkin  = bw_yaz_g && (bw_hedef_g != 5'd0) && !w_durdur;

        w_cek       = !w_bw_etkin && !w_bos;
        w_baypas    = !w_bw_etkin && w_bos && w_gc_gecerli_hdf;
        w_it        = w_gc_gecerli_hdf && !w_baypas;
    end

    assign gc_hazir_c    = w_hazir;
    assign boru_durdur_c = w_durdur;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        yaz_ptr_d  = yaz_ptr_q;
        oku_ptr_d  = oku_ptr_q;
        sayac_d    = sayac_q;
        yas_d      = yas_q;
        yo_yaz_d   = 1'b0;
        yo_hedef_d = yo_hedef_q;
        yo_veri_d  = yo_veri_q;

        // Pointers wrap modulo the depth, which need not be a power of two.
        if (w_it) begin
            yaz_ptr_d = (yaz_ptr_q == C_PTR_SON) ? '0 : yaz_ptr_q + 1'b1;
        end
        if (w_cek) begin
            oku_ptr_d = (oku_ptr_q == C_PTR_SON) ? '0 : oku_ptr_q + 1'b1;
        end

        // Simultaneous push and pop leave the occupancy unchanged.
        case ({w_it, w_cek})
            2'b10:   sayac_d = sayac_q + 4'd1;
            2'b01:   sayac_d = sayac_q - 4'd1;
            default: sayac_d = sayac_q;
        endcase

        // Age of the current head: restarts on every pop so that a FIFO
        // that stays non-empty gets a fresh ESIK window per entry.
        if (w_bos || w_cek) begin
            yas_d = '0;
        end else if (!w_yas_doldu) begin
            yas_d = yas_q + 1'b1;
        end

        // Write slot selection, highest priority first.
        if (w_bw_etkin) begin
            yo_yaz_d   = 1'b1;
            yo_hedef_d = bw_hedef_g;
            yo_veri_d  = bw_veri_g;
        end else if (w_cek) begin
            yo_yaz_d   = 1'b1;
            yo_hedef_d = w_bas[C_ENT_W-1 -: 5];
            yo_veri_d  = w_bas[31:0];
        end else if (w_baypas) begin
            yo_yaz_d   = 1'b1;
            yo_hedef_d = gc_hedef_g;
            yo_veri_d  = gc_veri_g;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_g or negedge rstn_g) begin
        if (!rstn_g) begin
            yaz_ptr_q  <= '0;
            oku_ptr_q  <= '0;
            sayac_q    <= 4'd0;
            yas_q      <= '0;
            yo_yaz_q   <= 1'b0;
            yo_hedef_q <= 5'd0;
            yo_veri_q  <= 32'd0;
        end else begin
            yaz_ptr_q  <= yaz_ptr_d;
            oku_ptr_q  <= oku_ptr_d;
            sayac_q    <= sayac_d;
            yas_q      <= yas_d;
            yo_yaz_q   <= yo_yaz_d;
            yo_hedef_q <= yo_hedef_d;
            yo_veri_q  <= yo_veri_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written,
    // and reset empties the FIFO through the pointers and count.
    always_ff @(posedge clk_g) begin
        if (w_it) begin
            kuyruk_q[yaz_ptr_q] <= {gc_hedef_g, gc_veri_g};
        end
    end

    assign yo_yaz_c       = yo_yaz_q;
    assign yo_yaz_hedef_c = yo_hedef_q;
    assign yo_yaz_veri_c  = yo_veri_q;
    assign doluluk_c      = sayac_q;

endmodule
`default_nettype wire

// File: tb/tb_yazmac_yaz_hakem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_yazmac_yaz_hakem
//  Purpose  : Self-checking bench for yazmac_yaz_hakem. A queue-based model
//             of the arbitration rules predicts ready, stall, the registered
//             write port and occupancy for directed and random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_yazmac_yaz_hakem;

    localparam int DERINLIK = 2;
    localparam int ESIK     = 4;

    logic        clk_g = 1'b0;
    logic        rstn_g;
    logic        bw_yaz_g;
    logic [4:0]  bw_hedef_g;
    logic [31:0] bw_veri_g;
    logic        gc_gecerli_g;
    logic [4:0]  gc_hedef_g;
    logic [31:0] gc_veri_g;
    logic        gc_hazir_c;
    logic        boru_durdur_c;
    logic        yo_yaz_c;
    logic [4:0]  yo_yaz_hedef_c;
    logic [31:0] yo_yaz_veri_c;
    logic [3:0]  doluluk_c;

    always #5 clk_g = ~clk_g;

    yazmac_yaz_hakem #(
        .DERINLIK (DERINLIK),
        .ESIK     (ESIK)
    ) dut (
        .clk_g          (clk_g),
        .rstn_g         (rstn_g),
        .bw_yaz_g       (bw_yaz_g),
        .bw_hedef_g     (bw_hedef_g),
        .bw_veri_g      (bw_veri_g),
        .gc_gecerli_g   (gc_gecerli_g),
        .gc_hedef_g     (gc_hedef_g),
        .gc_veri_g      (gc_veri_g),
        .gc_hazir_c     (gc_hazir_c),
        .boru_durdur_c  (boru_durdur_c),
        .yo_yaz_c       (yo_yaz_c),
        .yo_yaz_hedef_c (yo_yaz_hedef_c),
        .yo_yaz_veri_c  (yo_yaz_veri_c),
        .doluluk_c      (doluluk_c)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: buffered late results in arrival order, and the number
    // of consecutive cycles the current head has waited without being served.
    logic [36:0] model_q[$];
    int          model_age = 0;
    int          stall_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bw_yaz_g     = 1'b0;
        bw_hedef_g   = 5'd0;
        bw_veri_g    = 32'd0;
        gc_gecerli_g = 1'b0;
        gc_hedef_g   = 5'd0;
        gc_veri_g    = 32'd0;
    endtask

    // One clock cycle: apply inputs, check combinational outputs against the
    // model, advance the model, then check the registered outputs.
    task automatic step(input logic by, input logic [4:0] bh, input logic [31:0] bv,
                        input logic gv, input logic [4:0] gh, input logic [31:0] gd);
        logic        m_hazir;
        logic        m_durdur;
        logic        bw_eff;
        logic        hs;
        logic        wr;
        logic        popped;
        logic        bypassed;
        logic        was_empty;
        logic [4:0]  eh;
        logic [31:0] ev;
        logic [36:0] head;

        bw_yaz_g     = by;
        bw_hedef_g   = bh;
        bw_veri_g    = bv;
        gc_gecerli_g = gv;
        gc_hedef_g   = gh;
        gc_veri_g    = gd;
        #1;

        m_hazir  = (model_q.size() < DERINLIK);
        m_durdur = (model_q.size() > 0) && (!m_hazir || model_age >= ESIK);
        chk("gc_hazir", 32'(gc_hazir_c), 32'(m_hazir));
        chk("boru_durdur", 32'(boru_durdur_c), 32'(m_durdur));
        if (boru_durdur_c) stall_seen++;

        was_empty = (model_q.size() == 0);
        bw_eff    = by && (bh != 5'd0) && !m_durdur;
        hs        = gv && m_hazir;
        wr = 1'b0; popped = 1'b0; bypassed = 1'b0; eh = 5'd0; ev = 32'd0;

        if (bw_eff) begin
            wr = 1'b1; eh = bh; ev = bv;
        end else if (!was_empty) begin
            head = model_q.pop_front();
            wr = 1'b1; eh = head[36:32]; ev = head[31:0]; popped = 1'b1;
        end else if (hs && gh != 5'd0) begin
            wr = 1'b1; eh = gh; ev = gd; bypassed = 1'b1;
        end
        if (hs && gh != 5'd0 && !bypassed) model_q.push_back({gh, gd});

        if (was_empty || popped) model_age = 0;
        else if (model_age < ESIK) model_age++;

        @(posedge clk_g);
        #1;
        chk("yo_yaz", 32'(yo_yaz_c), 32'(wr));
        if (wr) begin
            chk("yo_yaz_hedef", 32'(yo_yaz_hedef_c), 32'(eh));
            chk("yo_yaz_veri", yo_yaz_veri_c, ev);
        end
        chk("doluluk", 32'(doluluk_c), 32'(model_q.size()));
    endtask

    initial begin
        rstn_g = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk_g);
        #4 rstn_g = 1'b1;
        #2;

        // Reset state
        chk("rst_yo_yaz", 32'(yo_yaz_c), 32'd0);
        chk("rst_yo_hedef", 32'(yo_yaz_hedef_c), 32'd0);
        chk("rst_yo_veri", yo_yaz_veri_c, 32'd0);
        chk("rst_doluluk", 32'(doluluk_c), 32'd0);
        chk("rst_hazir", 32'(gc_hazir_c), 32'd1);
        chk("rst_durdur", 32'(boru_durdur_c), 32'd0);

        // Single pipeline write, then idle
        step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Bypass with empty FIFO
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA5);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // One buffered result under continuous pipeline traffic: aged stall
        stall_seen = 0;
        step(1'b1, 5'd9, 32'h900, 1'b1, 5'd3, 32'hC3);
        for (int i = 0; i < 7; i++) step(1'b1, 5'd9, 32'h901 + i, 1'b0, 5'd0, 32'd0);
        chk("aged_stall_cycles", 32'(stall_seen), 32'd1);
        chk("aged_drained", 32'(doluluk_c), 32'd0);

        // Fill to capacity under traffic; a third offer while full is refused
        step(1'b1, 5'd9, 32'hA00, 1'b1, 5'd11, 32'h11);
        step(1'b1, 5'd9, 32'hA01, 1'b1, 5'd12, 32'h12);
        chk("full_hazir", 32'(gc_hazir_c), 32'd0);
        step(1'b1, 5'd9, 32'hA02, 1'b1, 5'd13, 32'h13);
        for (int i = 0; i < 4; i++) step(1'b1, 5'd9, 32'hA03 + i, 1'b0, 5'd0, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // x0 targets from both sources
        step(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Reset with two entries buffered and a write in flight
        step(1'b1, 5'd9, 32'hB00, 1'b1, 5'd14, 32'h14);
        step(1'b1, 5'd9, 32'hB01, 1'b1, 5'd15, 32'h15);
        chk("pre_rst_doluluk", 32'(doluluk_c), 32'd2);
        drive_idle();
        rstn_g = 1'b0;
        #1;
        chk("midrst_yo_yaz", 32'(yo_yaz_c), 32'd0);
        chk("midrst_doluluk", 32'(doluluk_c), 32'd0);
        chk("midrst_hazir", 32'(gc_hazir_c), 32'd1);
        chk("midrst_durdur", 32'(boru_durdur_c), 32'd0);
        model_q.delete();
        model_age = 0;
        #3 rstn_g = 1'b1;
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] bh;
            logic [4:0] gh;
            bh = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            gh = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(1'($urandom_range(0, 3) != 0), bh, $urandom,
                 1'($urandom_range(0, 1)), gh, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
